// File: rtl/wave_gen_pkg.sv
// Shared types and constants for the square-wave phase generator.
// Duty codes 0..10 select 0%..100% duty; larger codes are silenced.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } wave_state_e;

    localparam logic [3:0] DUTY_0   = 4'd0;
    localparam logic [3:0] DUTY_10  = 4'd1;
    localparam logic [3:0] DUTY_20  = 4'd2;
    localparam logic [3:0] DUTY_30  = 4'd3;
    localparam logic [3:0] DUTY_40  = 4'd4;
    localparam logic [3:0] DUTY_50  = 4'd5;
    localparam logic [3:0] DUTY_60  = 4'd6;
    localparam logic [3:0] DUTY_70  = 4'd7;
    localparam logic [3:0] DUTY_80  = 4'd8;
    localparam logic [3:0] DUTY_90  = 4'd9;
    localparam logic [3:0] DUTY_100 = 4'd10;
    localparam logic [3:0] DUTY_MAX = DUTY_100;

    localparam int LUT_ADDR_W = 10;
    localparam int LUT_DATA_W = 16;

    // Illegal duty codes map to silence rather than wrapping around.
    function automatic logic [3:0] duty_clamp(input logic [3:0] d);
        return (d > DUTY_MAX) ? DUTY_0 : d;
    endfunction

endpackage

// File: rtl/wave_phase_gen_if.sv
// Sample stream toward the DAC / output formatter.
// Valid/ready handshake with a period-start qualifier.
interface wave_phase_gen_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] sample;
    logic              valid;
    logic              ready;
    logic              wrap;

    modport master (
        output sample,
        output valid,
        output wrap,
        input  ready
    );

    modport slave (
        input  sample,
        input  valid,
        input  wrap,
        output ready
    );
endinterface

// File: rtl/wave_phase_acc.sv
// Phase accumulator: register, adder, carry detect, step enable.
// Exposes only the LUT address slice plus the carry of the next step.
module wave_phase_acc #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_step,
    input  logic [ACC_W-1:0]  i_ftw,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_carry
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, i_ftw};
    assign o_carry = w_sum[ACC_W];
    assign o_addr  = r_acc[ACC_W-1 -: ADDR_W];

    // Accumulate on each step, hold otherwise, clear when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= w_sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/wave_phase_gen.sv
// Phase-accumulator LUT address generator and sample reader.
// Optional WAVE_GEN_PHASE_OFFSET_EN adds a latched address offset.
module wave_phase_gen
    import wave_gen_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int DATA_W = LUT_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [ACC_W-1:0]  i_ftw,
    input  logic [3:0]        i_duty,
`ifdef WAVE_GEN_PHASE_OFFSET_EN
    input  logic [ADDR_W-1:0] i_phase_off,
`endif
    output logic [ADDR_W-1:0] o_lut_addr,
    output logic [3:0]        o_lut_sel,
    input  logic [DATA_W-1:0] i_lut_data,
    wave_phase_gen_if.master  o_smp
);

    wave_state_e       r_state;
    logic [ACC_W-1:0]  r_ftw_act;
    logic [3:0]        r_sel_act;
    logic [ADDR_W-1:0] r_off_act;
    logic              r_wrap_pend;
    logic [DATA_W-1:0] r_sample;
    logic              r_valid;
    logic              r_wrap;

    logic [ADDR_W-1:0] w_acc_addr;
    logic [ADDR_W-1:0] w_off_in;
    logic              w_carry;
    logic              w_free;
    logic              w_step;
    logic              w_stop;
    logic              w_clr;

`ifdef WAVE_GEN_PHASE_OFFSET_EN
    assign w_off_in = i_phase_off;
`else
    assign w_off_in = '0;
`endif

    // Output slot is free when empty or being consumed this edge.
    assign w_free = !r_valid || o_smp.ready;
    assign w_step = (r_state == ST_RUN) && i_en && w_free;
    assign w_stop = ((r_state == ST_RUN) && !i_en && w_free)
                 || ((r_state == ST_DRAIN) && o_smp.ready);
    assign w_clr  = (r_state == ST_IDLE) || w_stop;

    wave_phase_acc #(
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W)
    ) u_acc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_step  (w_step),
        .i_ftw   (r_ftw_act),
        .o_addr  (w_acc_addr),
        .o_carry (w_carry)
    );

    assign o_lut_addr   = w_acc_addr + r_off_act;
    assign o_lut_sel    = r_sel_act;
    assign o_smp.sample = r_sample;
    assign o_smp.valid  = r_valid;
    assign o_smp.wrap   = r_wrap;

    // Control FSM with sample capture; parameters relatch only on wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ftw_act   <= '0;
            r_sel_act   <= '0;
            r_off_act   <= '0;
            r_wrap_pend <= 1'b0;
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (i_en) begin
                        r_ftw_act   <= i_ftw;
                        r_sel_act   <= duty_clamp(i_duty);
                        r_off_act   <= w_off_in;
                        r_wrap_pend <= 1'b1;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_step) begin
                        r_sample    <= i_lut_data;
                        r_valid     <= 1'b1;
                        r_wrap      <= r_wrap_pend;
                        r_wrap_pend <= w_carry;
                        if (w_carry) begin
                            r_ftw_act <= i_ftw;
                            r_sel_act <= duty_clamp(i_duty);
                            r_off_act <= w_off_in;
                        end
                    end else if (!i_en) begin
                        if (w_free) begin
                            r_valid <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (o_smp.ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wave_phase_gen.md
# wave_phase_gen

Phase-accumulator address generator and sample reader for the square-wave lookup table (`squareLUT`). It drives the LUT address and duty-select inputs and captures the 16-bit LUT output into a registered sample stream. The stream uses a valid/ready handshake toward the DAC or output formatter. It sits between the control registers (frequency tuning word, duty select) and the DAC path of the wave generator.

## Interface
- `ACC_W`, 32: phase accumulator width.
- `ADDR_W`, 10: LUT address width; address = `acc[ACC_W-1 -: ADDR_W]`.
- `DATA_W`, 16: LUT data/sample width.
- `i_clk`  in  1  single clock; all logic is rising-edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_en`  in  1  run request; level-sensitive.
- `i_ftw`  in  ACC_W  frequency tuning word.
- `i_duty`  in  4  duty select: 0..10 maps to 0%..100%; values 11..15 are illegal.
- `o_lut_addr`  out  ADDR_W  LUT read address.
- `o_lut_sel`  out  4  LUT duty select.
- `i_lut_data`  in  DATA_W  LUT read data; combinational, same cycle as the address.
- `o_sample`  out  DATA_W  captured sample.
- `o_valid`  out  1  sample valid.
- `i_ready`  in  1  downstream accepts the sample.
- `o_wrap`  out  1  qualifies `o_sample` as the first sample of a waveform period.

## Operation
- State machine: IDLE, RUN, DRAIN.
- **IDLE:**
  - `acc`=0, `o_valid`=0.
  - When `i_en`=1: latch `ftw_act`←`i_ftw` and `sel_act`←clamp(`i_duty`), set `wrap_pend`=1, go to RUN.
- **RUN:**
  - Step condition: `step = !o_valid || i_ready`.
  - On step:
    - `o_sample`←`i_lut_data`
    - `o_valid`←1
    - `o_wrap`←`wrap_pend`
    - `acc`←`acc`+`ftw_act` (mod 2^ACC_W)
    - `wrap_pend`←carry-out of that addition
  - On a step with carry: also re-latch `ftw_act` and `sel_act` from the inputs. Parameter changes take effect only at period boundaries, which keeps the waveform glitch-free.
  - When `i_en`=0 and (`o_valid`=0 or `i_ready`=1): go to IDLE, clear `o_valid`, no step.
  - When `i_en`=0 and `o_valid`=1 and `i_ready`=0: go to DRAIN, no step.
- **DRAIN:**
  - Hold `o_sample`, `o_valid`, `o_wrap` stable.
  - On `i_ready`: clear `o_valid`, go to IDLE. A pending sample is never dropped.
- `o_lut_addr` = top ADDR_W bits of `acc`; `o_lut_sel` = `sel_act`. Both are driven directly from registers (glitch-free).
- `clamp`: `i_duty` > 10 → 0 (output silence).
- `ftw_act`=0 in RUN: the address is frozen and the same sample is re-emitted on every step; legal.
- Backpressure (`o_valid`=1, `i_ready`=0 in RUN): `acc`, `o_sample`, `o_wrap` and latched parameters are all held.
- **Reset** (any time, including mid-run):
  - `acc`=0, `ftw_act`=0, `sel_act`=0, `wrap_pend`=0
  - `o_sample`=0, `o_valid`=0, `o_wrap`=0
  - state=IDLE
  - `o_lut_addr`=0, `o_lut_sel`=0

## Timing
- Latency: `i_en` rising → first `o_valid`=1 after 2 clock edges: IDLE→RUN, then first step.
- Sample k holds `LUT[sel][addr(k·ftw)]`; with `i_ready` tied to 1, RUN produces one sample per cycle.
- `o_wrap`=1 on the first sample after start and on the first sample of each new period.
- Valid/ready: a transfer occurs on the edge where `o_valid` and `i_ready` are both 1. `o_valid` never drops without a transfer, except on reset.
- `i_en` drop with no backpressure: `o_valid` is 0 the next cycle.

## Configuration
- `WAVE_GEN_PHASE_OFFSET_EN` defined:
  - Adds port `i_phase_off` (in, ADDR_W), latched with `sel_act` at start and at each wrap.
  - `o_lut_addr` = `acc` top bits + `phase_off_act` (mod 2^ADDR_W).
- Undefined: no port; offset is 0.

## Structure
- Package `wave_gen_pkg`:
  - State enum `wave_state_e`
  - Duty constants `DUTY_0` … `DUTY_100` (0..10)
  - `DUTY_MAX`=10
  - `LUT_ADDR_W`=10, `LUT_DATA_W`=16
- Sub-module `wave_phase_acc`: accumulator register, adder, carry/wrap detect and hold enable. The FSM and sample register live in the top module.

## Test plan
- Reset mid-run:
  - Stimulus: `i_duty`=5, `i_en`=1, assert `i_rst_n`=0 for 1 cycle.
  - Required: all outputs 0 immediately and asynchronously; after release, restart from `o_lut_addr`=0.
- Full-period sweep:
  - Stimulus: `i_ftw`=0x0040_0000 (address +1 per step), `i_duty`=5, `i_ready`=1.
  - Required: `o_lut_addr` sequences 0..1023,0; samples match LUT50; `o_wrap`=1 on samples 0 and 1024 only.
- Duty change at boundary:
  - Stimulus: switch `i_duty` 5→2 at address 300.
  - Required: `o_lut_sel` stays 5 until the wrap step, then becomes 2; first LUT20 sample carries `o_wrap`=1.
- Backpressure:
  - Stimulus: `i_ready`=0 for 5 cycles at address 100.
  - Required: `o_sample`, `o_wrap` and address held; the next accepted sample is address 101; no sample skipped or duplicated.
- Stop with pending sample:
  - Stimulus: `i_en`→0 while `o_valid`=1 and `i_ready`=0.
  - Required: DRAIN holds the sample; one transfer on `i_ready`; then `o_valid`=0 and `acc`=0.
- Duty corner values:
  - Stimulus: `i_duty`=10 → samples 0xFFFF; `i_duty`=0 → 0x0000; `i_duty`=13 → `o_lut_sel`=0, samples 0x0000.
  - Offset variant (`WAVE_GEN_PHASE_OFFSET_EN` defined): `i_phase_off`=512 → first address 512.
